// File: rtl/ofb_stream_dec.sv
// OFB-mode DES stream decryptor: iterates one combinational DES encryption
// core to produce the keystream and XORs it into handshaked ciphertext blocks.

// Combinational DES encryption core (single block, 16 rounds unrolled).
module des_core (
    input  logic [64:1] key,
    input  logic [64:1] din,
    output logic [64:1] dout
);
    localparam int IP [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};
    localparam int EX [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
                               12,13,14,15,16,17, 16,17,18,19,20,21,
                               20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int PP [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    // Each S-box is 64 nibbles, entry 0 in the top nibble, row-major (row = outer bits).
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    // Ascending [1:N] vectors so that DES bit n is simply v[n].
    function automatic logic [1:64] des_enc(input logic [1:64] k, input logic [1:64] pt);
        logic [1:56]  cd;
        logic [1:28]  c, d;
        logic [1:48]  sk, ex;
        logic [1:32]  l, r, s, f, t;
        logic [1:64]  x, pre, ct;
        logic [5:0]   b;
        logic [255:0] row;
        int           idx;
        for (int i = 0; i < 56; i++) cd[i+1] = k[PC1[i]];
        c = cd[1:28];
        d = cd[29:56];
        for (int i = 0; i < 64; i++) x[i+1] = pt[IP[i]];
        l = x[1:32];
        r = x[33:64];
        for (int rd = 0; rd < 16; rd++) begin
            if (SHIFTS[rd] == 1) begin
                c = {c[2:28], c[1]};
                d = {d[2:28], d[1]};
            end else begin
                c = {c[3:28], c[1:2]};
                d = {d[3:28], d[1:2]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) sk[i+1] = cd[PC2[i]];
            for (int i = 0; i < 48; i++) ex[i+1] = r[EX[i]];
            ex = ex ^ sk;
            for (int j = 0; j < 8; j++) begin
                b   = ex[6*j+1 +: 6];
                idx = {26'd0, b[5], b[0], b[4:1]};
                row = SBOX[j];
                s[4*j+1 +: 4] = row[255 - 4*idx -: 4];
            end
            for (int i = 0; i < 32; i++) f[i+1] = s[PP[i]];
            t = r;
            r = l ^ f;
            l = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) ct[i+1] = pre[FP[i]];
        return ct;
    endfunction

    assign dout = des_enc(key, din);
endmodule

module ofb_stream_dec #(
    parameter int DES_LAT = 2,
    parameter int CNT_W   = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [64:1]      key,
    input  logic [64:1]      iv,
    input  logic [CNT_W:1]   num_blocks,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [64:1]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [64:1]      out_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W:1]   block_cnt
);
    localparam int SW = (DES_LAT > 1) ? $clog2(DES_LAT) : 1;

    typedef enum logic [1:0] {IDLE, GEN, XFER, DRAIN} state_t;

    state_t          state, state_n;
    logic [64:1]     key_r, fb_r, ks_r, des_out;
    logic [CNT_W:1]  nblk_r, blk_inc;
    logic [SW-1:0]   settle;
    logic            settle_last, hs, last_blk, drain_ok, accept, zero_job;

    // Keystream generator: feedback reg encrypted under the job key.
    des_core u_des (
        .key  (key_r),
        .din  (fb_r),
        .dout (des_out)
    );

    assign blk_inc = block_cnt + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept)      state_n = GEN;
            GEN:     if (settle_last) state_n = XFER;
            XFER:    if (hs)          state_n = last_blk ? DRAIN : GEN;
            DRAIN:   if (drain_ok)    state_n = IDLE;
            default:                  state_n = IDLE;
        endcase
    end

    // Handshake and status decode from the current state.
    always_comb begin
        in_ready    = (state == XFER) && (!out_valid || out_ready);
        busy        = (state != IDLE);
        hs          = in_valid && in_ready;
        last_blk    = (blk_inc == nblk_r);
        settle_last = (state == GEN) && (settle == SW'(DES_LAT - 1));
        drain_ok    = (state == DRAIN) && (!out_valid || out_ready);
        accept      = (state == IDLE) && start && (num_blocks != '0);
        zero_job    = (state == IDLE) && start && (num_blocks == '0);
    end

    // Job context, keystream, output register and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_r     <= '0;
            fb_r      <= '0;
            ks_r      <= '0;
            nblk_r    <= '0;
            block_cnt <= '0;
            settle    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= zero_job || drain_ok;
            if (accept) begin
                key_r     <= key;
                fb_r      <= iv;
                nblk_r    <= num_blocks;
                block_cnt <= '0;
            end
            // Settle counter only runs in GEN, so it is zero on every GEN entry.
            if (state == GEN) settle <= settle_last ? '0 : settle + 1'b1;
            if (settle_last)  ks_r   <= des_out;
            // Keystream advances only on an accepted block, never on a stall.
            if (hs) begin
                out_data  <= in_data ^ ks_r;
                out_valid <= 1'b1;
                fb_r      <= ks_r;
                block_cnt <= blk_inc;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/ofb_stream_dec.md
Name: ofb_stream_dec

Overview:
- Sequential OFB decryption engine for streams of 64-bit DES blocks. Decrypts up to 131072 blocks per job.
- Generates the OFB keystream K_i = DES_E(key, K_(i-1)), with K_0 = iv, by iterating one instance of the team's combinational DES encryption core.
- XORs each keystream block with the incoming ciphertext block and emits the plaintext.
- Sits between the ciphertext block source (file/stream loader) and the plaintext sink. It is the clocked, handshaked replacement for driving the combinational OFB decrypt path one block at a time.

Parameters:
- DES_LAT, 2, settle cycles allowed for the combinational DES core before its output is captured (min 1)
- CNT_W, 18, width of the block counter and num_blocks (must hold 131072)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle job start; sampled only in IDLE
- key  in  [64:1]  DES key; sampled at start, held internally for the job
- iv  in  [64:1]  initialisation vector; sampled at start
- num_blocks  in  [CNT_W:1]  blocks in this job; sampled at start
- in_valid  in  1  ciphertext block valid
- in_ready  out  1  engine accepts ciphertext this cycle
- in_data  in  [64:1]  ciphertext block
- out_valid  out  1  plaintext block valid
- out_ready  in  1  sink accepts plaintext this cycle
- out_data  out  [64:1]  plaintext block
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the job completes
- block_cnt  out  [CNT_W:1]  ciphertext blocks accepted in the current job

Behaviour:
- Reset (synchronous, active-high) sets all of the following: state=IDLE, in_ready=0, out_valid=0, out_data=0, busy=0, done=0, block_cnt=0, feedback reg=0, key reg=0, settle counter=0.
- Reset dominates every other input in the same cycle. Reset mid-job abandons the job; no done pulse is produced.
- States: IDLE, GEN, XFER, DRAIN.
- IDLE:
  - start=1 with num_blocks!=0: latch key, iv (into the feedback reg) and num_blocks; clear block_cnt; go to GEN.
  - start=1 with num_blocks==0: pulse done the next cycle, stay IDLE, busy stays 0.
- GEN:
  - DES core input is the feedback reg; core key is the latched key.
  - The settle counter runs DES_LAT cycles. On the last one, capture the core output into the keystream reg and go to XFER.
  - First in_ready occurs DES_LAT+1 cycles after start is sampled.
- XFER:
  - in_ready = !out_valid || out_ready.
  - On handshake (in_valid && in_ready):
    - out_data <= in_data XOR keystream reg; out_valid <= 1 the next cycle.
    - feedback reg <= keystream reg; block_cnt <= block_cnt+1.
    - If block_cnt+1 == num_blocks, go to DRAIN; otherwise go to GEN.
- Output register:
  - out_valid, once high, holds with out_data stable until out_ready=1.
  - out_valid && out_ready with no new handshake clears out_valid.
  - A simultaneous output accept and input handshake (possible in XFER) loads the new block with out_valid kept at 1.
- DRAIN: wait until out_valid=0, or until out_valid && out_ready. Then pulse done for one cycle, drop busy, and go to IDLE.
- Output rules:
  - in_ready=0 in IDLE, GEN and DRAIN.
  - start while busy is ignored.
  - key/iv/num_blocks changes after start have no effect on the running job.
- The keystream depends only on key and iv, never on data. Input stalls (in_valid=0) must not advance the keystream.

Test Plan:
- key=64'h133457799BBCDFF1, iv=64'h0123456789ABCDEF, num_blocks=1, in_data=64'h0 -> out_data=64'h85E813540F0AB405; done pulses once; block_cnt=1.
- Same key/iv, in_data=64'h85E813540F0AB405 -> out_data=64'h0. Also check in_ready first rises exactly DES_LAT+1 cycles after start.
- Same key/iv, num_blocks=8, random ciphertext with random in_valid gaps and out_ready stalls -> all 8 outputs match a software OFB model in order. out_data is stable while stalled, and there is no loss or duplication.
- Encrypt-then-decrypt loop: feed num_blocks=131072 blocks that were OFB-encrypted with the same key/iv -> recovered plaintext is bit-exact. block_cnt ends at 131072 with a single done pulse.
- num_blocks=0 with start -> done pulses next cycle; busy, in_ready and out_valid stay 0.
- Assert rst mid-job after 3 blocks -> next cycle all outputs are at their reset values. A subsequent start with iv=64'h0123456789ABCDEF reproduces 64'h85E813540F0AB405 as the first keystream block.
